// File: rtl/e_mdu_pkg.sv
// Shared MDU constants: operation codes, FSM state encoding and counter width.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  localparam int CNT_W = 5;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Operand/result bundle between the EX stage and the MDU.
// Start qualifies MDUOp/A/B for one cycle; it is accepted only while Busy is low,
// otherwise it is dropped (upstream is expected to stall on (Busy|Start) & op != NONE).
interface e_mdu_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDURes;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO, MDURes);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO, MDURes);
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit: results computed at acceptance, held in temp registers,
// committed to HI/LO after a fixed busy window.
module e_mdu
  import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    e_mdu_if.slave     bus,
    output mdu_state_e dbg_state
);

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             busy;
    logic [31:0]      hi, lo, temp_hi, temp_lo;
    logic             load_mul, load_div, commit, wr_hi, wr_lo;

    logic        sgn;
    logic [63:0] a_ext, b_ext, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Division works on magnitudes so INT_MIN / -1 wraps instead of overflowing.
    assign sgn   = is_signed_op(bus.MDUOp);
    assign a_ext = sgn ? {{32{bus.A[31]}}, bus.A} : {32'b0, bus.A};
    assign b_ext = sgn ? {{32{bus.B[31]}}, bus.B} : {32'b0, bus.B};
    assign prod  = a_ext * b_ext;
    assign a_neg = sgn & bus.A[31];
    assign b_neg = sgn & bus.B[31];
    assign a_mag = a_neg ? (~bus.A + 32'd1) : bus.A;
    assign b_mag = b_neg ? (~bus.B + 32'd1) : bus.B;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.MDUOp)
                        MDU_MULT, MDU_MULTU: begin
                            state_next = MUL;
                            cnt_next   = CNT_W'(MULT_CYCLES);
                            load_mul   = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_next = DIV;
                            cnt_next   = CNT_W'(DIV_CYCLES);
                            load_div   = 1'b1;
                        end
                        MDU_MTHI: wr_hi = 1'b1;
                        MDU_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    commit     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);
            if (load_mul) begin
                temp_hi <= prod[63:32];
                temp_lo <= prod[31:0];
            end
            // Divide by zero re-commits the current HI/LO, leaving them unchanged.
            if (load_div) begin
                temp_hi <= (bus.B == 32'd0) ? hi : rem;
                temp_lo <= (bus.B == 32'd0) ? lo : quot;
            end
            if (commit) begin
                hi <= temp_hi;
                lo <= temp_lo;
            end
            if (wr_hi) hi <= bus.A;
            if (wr_lo) lo <= bus.A;
        end
    end

    assign bus.Busy   = busy;
    assign bus.HI     = hi;
    assign bus.LO     = lo;
    assign bus.MDURes = (bus.MDUOp == MDU_MFHI) ? hi :
                        (bus.MDUOp == MDU_MFLO) ? lo : 32'd0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed vector table, hand-written multi-cycle corners,
// and random operations against a 64-bit arithmetic reference model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    mdu_state_e dbg_state;
    e_mdu_if    bus ();

    always #5 clk = ~clk;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mhi, mlo;

    typedef struct {
        string       name;
        mdu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input string n, input mdu_op_e op, input logic [31:0] a, b, hi, lo,
                                input int cyc);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void ref_op(input mdu_op_e op, input logic [31:0] a, b,
                                   inout logic [31:0] hi, lo, output int cyc);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        cyc = 0;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        case (op)
            MDU_MULT: begin
                sq = sa * sb; hi = sq[63:32]; lo = sq[31:0]; cyc = MC;
            end
            MDU_MULTU: begin
                up = ua * ub; hi = up[63:32]; lo = up[31:0]; cyc = MC;
            end
            MDU_DIV: begin
                cyc = DC;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0];
                end
            end
            MDU_DIVU: begin
                cyc = DC;
                if (b != 0) begin
                    up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0];
                end
            end
            MDU_MTHI: hi = a;
            MDU_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    task automatic drive(input logic s, input mdu_op_e op, input logic [31:0] a, b);
        bus.Start = s; bus.MDUOp = op; bus.A = a; bus.B = b;
    endtask

    task automatic check_reads(input string name, input logic [31:0] ehi, elo);
        bus.MDUOp = MDU_MFHI; #1;
        check({name, "_mfhi"}, bus.MDURes, ehi);
        bus.MDUOp = MDU_MFLO; #1;
        check({name, "_mflo"}, bus.MDURes, elo);
        bus.MDUOp = MDU_NONE; #1;
        check({name, "_res_none"}, bus.MDURes, 32'd0);
    endtask

    task automatic run_op(input string name, input mdu_op_e op, input logic [31:0] a, b,
                          input logic [31:0] ehi, elo, input int ecyc);
        int          cnt;
        logic        stable;
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = bus.HI; lo0 = bus.LO; stable = 1'b1;
        drive(1'b1, op, a, b);
        @(negedge clk);
        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        cnt = 0;
        while (bus.Busy && cnt < 40) begin
            cnt++;
            if (bus.HI !== hi0 || bus.LO !== lo0) stable = 1'b0;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, cnt, ecyc);
        check({name, "_hilo_held"}, stable, 1'b1);
        check({name, "_hi"}, bus.HI, ehi);
        check({name, "_lo"}, bus.LO, elo);
        check({name, "_state_idle"}, dbg_state, IDLE);
        check_reads(name, ehi, elo);
    endtask

    initial begin
        int          cnt;
        int          cyc;
        logic [31:0] ehi, elo;
        mdu_op_e     rops[6] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};

        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.Busy, 1'b0);
        check("reset_hi", bus.HI, 32'd0);
        check("reset_lo", bus.LO, 32'd0);
        check("reset_state", dbg_state, IDLE);
        reset = 1'b1;

        vecs[0] = mk("mult_neg1x2",   MDU_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC);
        vecs[1] = mk("multu_big_x2",  MDU_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, MC);
        vecs[2] = mk("div_m7_2",      MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        vecs[3] = mk("divu_by_zero",  MDU_DIVU,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        vecs[4] = mk("mthi",          MDU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFD, 0);
        vecs[5] = mk("mtlo",          MDU_MTLO,  32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0);
        vecs[6] = mk("div_min_m1",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC);
        vecs[7] = mk("div_7_m2",      MDU_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC);
        vecs[8] = mk("divu_max_16",   MDU_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, DC);
        vecs[9] = mk("multu_max_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].cyc);

        // Start during busy cycle 3 of a divide must be dropped.
        @(negedge clk);
        drive(1'b1, MDU_DIV, 32'd100, 32'd7);
        @(negedge clk);
        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        cnt = 0;
        while (bus.Busy && cnt < 40) begin
            cnt++;
            if (cnt == 3) drive(1'b1, MDU_MULT, 32'd5, 32'd6);
            else          drive(1'b0, MDU_NONE, 32'd0, 32'd0);
            @(negedge clk);
        end
        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        check("ignore_busy_cycles", cnt, DC);
        check("ignore_hi", bus.HI, 32'd2);
        check("ignore_lo", bus.LO, 32'd14);
        @(negedge clk);
        check("ignore_no_late_start", bus.Busy, 1'b0);

        // Reset asserted mid-multiply aborts it.
        drive(1'b1, MDU_MULT, 32'd3, 32'd5);
        @(negedge clk);
        drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", bus.Busy, 1'b0);
        check("abort_hi", bus.HI, 32'd0);
        check("abort_lo", bus.LO, 32'd0);
        check("abort_state", dbg_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_commit_busy", bus.Busy, 1'b0);
        check("abort_no_commit_hi", bus.HI, 32'd0);
        check("abort_no_commit_lo", bus.LO, 32'd0);
        run_op("post_reset_multu", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, MC);

        mhi = 32'd0; mlo = 32'd12;
        for (int i = 0; i < 30; i++) begin
            mdu_op_e     op;
            logic [31:0] a, b;
            op = rops[$urandom_range(0, 5)];
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : 32'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : 32'($urandom);
            ref_op(op, a, b, mhi, mlo, cyc);
            exp_q.push_back(mhi);
            exp_q.push_back(mlo);
            ehi = exp_q.pop_front();
            elo = exp_q.pop_front();
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ehi, elo, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
